frame_channel_arbiter: RTL

- Shares the QPI request channels between the frame reader and the frame writer.
  - C0 carries RdLine requests.
  - C1 carries WrLine and WrFence requests.
- Produces per-requester read and write grants, and the channel valid/select used by the TX header mux.
- Round-robin on each channel independently.
- Throttles reads by an outstanding-read credit count.
- Write lock keeps a requester's fence-plus-control write pair contiguous on C1.

---
 rtl/frame_channel_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/frame_channel_arbiter.sv
// Arbitrates QPI C0 (RdLine) and C1 (WrLine/WrFence) between the frame reader and writer,
// with round-robin per channel, read-credit throttling and a C1 write lock for fence pairs.

module frame_channel_arbiter_chk #(
  parameter int CNT_WIDTH = 6
) (
  input logic                 clk,
  input logic                 resetb,
  input logic                 afu_en,
  input logic                 rd_rsp_valid,
  input logic                 tx0_valid,
  input logic [CNT_WIDTH-1:0] cnt
);

  // A response with nothing outstanding and no matching issue is a credit underflow
  a_no_underflow: assert property (@(posedge clk) disable iff (!resetb)
    !(afu_en && rd_rsp_valid && !tx0_valid && (cnt == {CNT_WIDTH{1'b0}})))
    else $error("read credit underflow");

endmodule

module frame_channel_arbiter #(
  parameter int MAX_OUTSTANDING_READS = 32,
  parameter int CNT_WIDTH             = 6
) (
  input  logic                 clk,
  input  logic                 resetb,
  input  logic                 afu_en,
  input  logic                 c0_almost_full,
  input  logic                 c1_almost_full,
  input  logic                 rd_rsp_valid,
  input  logic                 reader_rd_req,
  input  logic                 writer_rd_req,
  input  logic                 reader_wr_req,
  input  logic                 writer_wr_req,
  input  logic                 reader_wr_lock,
  input  logic                 writer_wr_lock,
  output logic                 reader_rd_grant,
  output logic                 writer_rd_grant,
  output logic                 reader_wr_grant,
  output logic                 writer_wr_grant,
  output logic                 tx0_valid,
  output logic                 tx0_sel,
  output logic                 tx1_valid,
  output logic                 tx1_sel,
  output logic [CNT_WIDTH-1:0] outstanding_reads,
  output logic                 wr_locked
);

  localparam logic [CNT_WIDTH-1:0] MAX_RD_C = CNT_WIDTH'(MAX_OUTSTANDING_READS);

  // Two-way round-robin pick; returns {writer_grant, reader_grant}. last=1 means writer won last.
  function automatic logic [1:0] rr_pick(input logic req_rdr, input logic req_wtr, input logic last);
    logic [1:0] g;
    case ({req_rdr, req_wtr})
      2'b10:   g = 2'b01;
      2'b01:   g = 2'b10;
      2'b11:   g = last ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

  logic                 rd_last_r;
  logic                 wr_last_r;
  logic                 wr_locked_r;
  logic                 wr_lock_owner_r;
  logic [CNT_WIDTH-1:0] rd_cnt_r;

  logic       active_s;
  logic       rd_ok_s;
  logic [1:0] rd_gnt_s;
  logic [1:0] wr_gnt_s;
  logic       wr_elig_rdr_s;
  logic       wr_elig_wtr_s;
  logic       wr_lock_sel_s;

  assign active_s = resetb && afu_en;
  assign rd_ok_s  = !c0_almost_full && (rd_cnt_r < MAX_RD_C);

  // C0 grant: round-robin gated by credits and TX space
  always_comb begin
    rd_gnt_s = 2'b00;
    if (active_s && rd_ok_s) begin
      rd_gnt_s = rr_pick(reader_rd_req, writer_rd_req, rd_last_r);
    end else begin
      rd_gnt_s = 2'b00;
    end
  end

  // C1 eligibility: a held lock excludes the non-owner even when the owner is idle
  always_comb begin
    wr_elig_rdr_s = reader_wr_req;
    wr_elig_wtr_s = writer_wr_req;
    if (wr_locked_r) begin
      wr_elig_rdr_s = reader_wr_req && !wr_lock_owner_r;
      wr_elig_wtr_s = writer_wr_req && wr_lock_owner_r;
    end else begin
      wr_elig_rdr_s = reader_wr_req;
      wr_elig_wtr_s = writer_wr_req;
    end
  end

  // C1 grant and the lock request of whoever wins
  always_comb begin
    wr_gnt_s      = 2'b00;
    wr_lock_sel_s = 1'b0;
    if (active_s && !c1_almost_full) begin
      wr_gnt_s = rr_pick(wr_elig_rdr_s, wr_elig_wtr_s, wr_last_r);
    end else begin
      wr_gnt_s = 2'b00;
    end
    if (wr_gnt_s[1]) begin
      wr_lock_sel_s = writer_wr_lock;
    end else begin
      wr_lock_sel_s = reader_wr_lock;
    end
  end

  // Arbitration history, read credits and write lock
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rd_last_r       <= 1'b1;
      wr_last_r       <= 1'b1;
      wr_locked_r     <= 1'b0;
      wr_lock_owner_r <= 1'b0;
      rd_cnt_r        <= {CNT_WIDTH{1'b0}};
    end else if (!afu_en) begin
      rd_last_r       <= 1'b1;
      wr_last_r       <= 1'b1;
      wr_locked_r     <= 1'b0;
      wr_lock_owner_r <= 1'b0;
      rd_cnt_r        <= {CNT_WIDTH{1'b0}};
    end else begin
      case ({tx0_valid, rd_rsp_valid})
        2'b10:   rd_cnt_r <= rd_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        2'b01:   rd_cnt_r <= (rd_cnt_r == {CNT_WIDTH{1'b0}}) ? rd_cnt_r
                                                             : rd_cnt_r - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        default: rd_cnt_r <= rd_cnt_r;
      endcase
      if (tx0_valid) begin
        rd_last_r <= rd_gnt_s[1];
      end
      if (tx1_valid) begin
        wr_last_r   <= wr_gnt_s[1];
        wr_locked_r <= wr_lock_sel_s;
        if (wr_lock_sel_s) begin
          wr_lock_owner_r <= wr_gnt_s[1];
        end
      end
    end
  end

  assign reader_rd_grant   = rd_gnt_s[0];
  assign writer_rd_grant   = rd_gnt_s[1];
  assign reader_wr_grant   = wr_gnt_s[0];
  assign writer_wr_grant   = wr_gnt_s[1];
  assign tx0_valid         = |rd_gnt_s;
  assign tx0_sel           = rd_gnt_s[1];
  assign tx1_valid         = |wr_gnt_s;
  assign tx1_sel           = wr_gnt_s[1];
  assign outstanding_reads = rd_cnt_r;
  assign wr_locked         = wr_locked_r;

  frame_channel_arbiter_chk #(.CNT_WIDTH(CNT_WIDTH)) u_chk (
    .clk          (clk),
    .resetb       (resetb),
    .afu_en       (afu_en),
    .rd_rsp_valid (rd_rsp_valid),
    .tx0_valid    (tx0_valid),
    .cnt          (rd_cnt_r)
  );

endmodule
